bcd_seg_display: RTL

//  Consumes the four BCD digits (Thousands/Hundreds/Tens/Ones) from the binary-to-BCD converter.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg7_decode.sv | 23 ++
 rtl/bcd_seg_display.sv | 67 ++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: active-low seven-segment patterns {g,f,e,d,c,b,a} and digit-enable constants
package seg_pkg;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low segment pattern; non-BCD codes show a dash
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_display.sv
// bcd_seg_display: double-buffered, time-multiplexed 4-digit common-anode display driver
module bcd_seg_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV      = 100_000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] thou,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    logic [TW-1:0] tick;
    logic [1:0]    scan_idx;
    logic [15:0]   shadow, active, in_val;
    logic          pending, last, boundary, blank;
    logic [3:0]    digit;
    logic [6:0]    dec;
    assign in_val   = {thou, hund, tens, ones};
    assign last     = tick == TW'(SCAN_DIV - 1);
    assign boundary = last && scan_idx == 2'd3;
    assign digit    = active[{scan_idx, 2'b00} +: 4];
    assign dp       = 1'b1;
    // a digit is blanked only when it and every digit to its left are zero
    always_comb begin
        blank = BLANK_LEADING && (scan_idx == 2'd3 ? active[15:12] == 4'd0 :
                                  scan_idx == 2'd2 ? active[15:8] == 8'd0 :
                                  scan_idx == 2'd1 ? active[15:4] == 12'd0 : 1'b0);
    end
    seg7_decode u_dec (.bcd(digit), .seg(dec));
    always_ff @(posedge clk) begin
        if (rst) begin
            tick       <= '0;
            scan_idx   <= 2'd0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            tick <= last ? '0 : tick + 1'b1;
            if (last)
                scan_idx <= scan_idx + 2'd1;
            if (load) begin
                shadow  <= in_val;
                pending <= !boundary;
                if (boundary)
                    active <= in_val;
            end else if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            an         <= blank ? AN_OFF : ~(4'b0001 << scan_idx);
            seg        <= blank ? SEG_OFF : dec;
            frame_done <= boundary;
        end
    end
endmodule
